// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational 16-bit Hack ALU between two requesters. The block
//   accepts an operation from one port, holds its operands and control word in
//   op registers that drive the ALU for one execute cycle, captures the ALU
//   result, and presents it on a response channel tagged with the requester ID.
//
// Ports
//   clk, rst                      : clock (rising edge), async active-high reset
//   reqN_valid / reqN_ready       : request handshake, N = 0,1
//   reqN_x, reqN_y, reqN_ctrl     : operands and control word {zx,nx,zy,ny,f,no}
//   alu_x, alu_y, alu_zx..alu_no  : registered drives into the shared ALU
//   alu_out, alu_zr, alu_ng       : ALU results (combinational from the drives)
//   rsp_valid / rsp_ready         : response handshake
//   rsp_id, rsp_out, rsp_zr, rsp_ng : owner ID and registered ALU result
//
// Parameters
//   WIDTH      : datapath width (16 for the Hack ALU)
//   FIXED_PRIO : 0 = round-robin on ties, 1 = port 0 always wins ties
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int unsigned WIDTH      = 16,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic [5:0]       req0_ctrl,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    input  logic [5:0]       req1_ctrl,

    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic             alu_zx,
    output logic             alu_nx,
    output logic             alu_zy,
    output logic             alu_ny,
    output logic             alu_f,
    output logic             alu_no,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zr,
    input  logic             alu_ng,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_zr,
    output logic             rsp_ng
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_last;       // ID of the requester that owned the last response
    logic             r_id;
    logic [WIDTH-1:0] r_op_x;
    logic [WIDTH-1:0] r_op_y;
    logic [5:0]       r_op_ctrl;
    logic [WIDTH-1:0] r_res_out;
    logic             r_res_zr;
    logic             r_res_ng;
    logic             r_rsp_valid;

    logic             w_idle;
    logic             w_pick1;
    logic             w_gnt0;
    logic             w_gnt1;

    // Readies are gated by rst so nothing looks accepted while reset is held.
    assign w_idle  = (r_state == S_IDLE) && !rst;
    // On a tie, round-robin hands the grant to the port that did not own the
    // last response; fixed priority always favours port 0.
    assign w_pick1 = FIXED_PRIO ? 1'b0 : !r_last;
    assign w_gnt0  = w_idle && req0_valid && (!req1_valid || !w_pick1);
    assign w_gnt1  = w_idle && req1_valid && (!req0_valid ||  w_pick1);

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // ALU drives come straight from the op registers, so they only change at
    // an accept edge and never glitch.
    assign alu_x  = r_op_x;
    assign alu_y  = r_op_y;
    assign alu_zx = r_op_ctrl[5];
    assign alu_nx = r_op_ctrl[4];
    assign alu_zy = r_op_ctrl[3];
    assign alu_ny = r_op_ctrl[2];
    assign alu_f  = r_op_ctrl[1];
    assign alu_no = r_op_ctrl[0];

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_id;
    assign rsp_out   = r_res_out;
    assign rsp_zr    = r_res_zr;
    assign rsp_ng    = r_res_ng;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_id        <= 1'b0;
            r_op_x      <= '0;
            r_op_y      <= '0;
            r_op_ctrl   <= '0;
            r_res_out   <= '0;
            r_res_zr    <= 1'b0;
            r_res_ng    <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt0) begin
                        r_op_x    <= req0_x;
                        r_op_y    <= req0_y;
                        r_op_ctrl <= req0_ctrl;
                        r_id      <= 1'b0;
                        r_state   <= S_EXEC;
                    end else if (w_gnt1) begin
                        r_op_x    <= req1_x;
                        r_op_y    <= req1_y;
                        r_op_ctrl <= req1_ctrl;
                        r_id      <= 1'b1;
                        r_state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_res_out   <= alu_out;
                    r_res_zr    <= alu_zr;
                    r_res_ng    <= alu_ng;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_last      <= r_id;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Two instances of alu_arbiter (round-robin and fixed priority) share the
//   same request/response stimulus; each is wired to its own behavioural Hack
//   ALU. A transaction-level model tracks, per instance, whether an operation
//   is in flight and how many cycles have passed since its accept, and
//   predicts grants, ALU drives and responses from the arbitration rules.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
    logic [15:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
    logic [5:0]  req0_ctrl = '0, req1_ctrl = '0;

    logic [1:0] req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zr, rsp_ng;
    logic [1:0] a_zx, a_nx, a_zy, a_ny, a_f, a_no, a_zr, a_ng;
    logic [1:0][15:0] a_x, a_y, a_out, rsp_out;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Model state, index = instance (0 round-robin, 1 fixed priority)
    bit          m_busy [2];
    int          m_age  [2];
    bit          m_last [2];
    bit          m_id   [2];
    logic [15:0] m_x    [2];
    logic [15:0] m_y    [2];
    logic [5:0]  m_c    [2];
    logic [17:0] m_res  [2];
    int          q0[$];
    int          q1[$];

    always #5 clk = ~clk;

    // Hack ALU semantics: returns {zr, ng, out}
    function automatic logic [17:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                             input logic [5:0] c);
        logic [15:0] a, b, o;
        a = c[5] ? 16'h0000 : x;
        if (c[4]) a = ~a;
        b = c[3] ? 16'h0000 : y;
        if (c[2]) b = ~b;
        o = c[1] ? (a + b) : (a & b);
        if (c[0]) o = ~o;
        return {(o == 16'h0000), o[15], o};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_arbiter #(.WIDTH(16), .FIXED_PRIO(g == 1)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req0_valid (req0_valid),
            .req0_ready (req0_ready[g]),
            .req0_x     (req0_x),
            .req0_y     (req0_y),
            .req0_ctrl  (req0_ctrl),
            .req1_valid (req1_valid),
            .req1_ready (req1_ready[g]),
            .req1_x     (req1_x),
            .req1_y     (req1_y),
            .req1_ctrl  (req1_ctrl),
            .alu_x      (a_x[g]),
            .alu_y      (a_y[g]),
            .alu_zx     (a_zx[g]),
            .alu_nx     (a_nx[g]),
            .alu_zy     (a_zy[g]),
            .alu_ny     (a_ny[g]),
            .alu_f      (a_f[g]),
            .alu_no     (a_no[g]),
            .alu_out    (a_out[g]),
            .alu_zr     (a_zr[g]),
            .alu_ng     (a_ng[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready),
            .rsp_id     (rsp_id[g]),
            .rsp_out    (rsp_out[g]),
            .rsp_zr     (rsp_zr[g]),
            .rsp_ng     (rsp_ng[g])
        );
        assign {a_zr[g], a_ng[g], a_out[g]} =
            hack_alu(a_x[g], a_y[g], {a_zx[g], a_nx[g], a_zy[g], a_ny[g], a_f[g], a_no[g]});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic string tg(input string s, input int i);
        return $sformatf("%s[%0d]", s, i);
    endfunction

    // Called just after a falling edge with the inputs for the next rising
    // edge already applied; returns just after the following falling edge.
    task automatic tick();
        int g;
        #1;
        for (int i = 0; i < 2; i++) begin
            g = -1;
            if (!m_busy[i]) begin
                if (req0_valid && req1_valid) g = (i == 1) ? 0 : (m_last[i] ? 0 : 1);
                else if (req0_valid)          g = 0;
                else if (req1_valid)          g = 1;
            end
            check(tg("req0_ready", i), {31'd0, req0_ready[i]}, {31'd0, (g == 0)});
            check(tg("req1_ready", i), {31'd0, req1_ready[i]}, {31'd0, (g == 1)});
            if (g >= 0) begin
                m_busy[i] = 1'b1;
                m_age[i]  = 0;
                m_id[i]   = (g == 1);
                m_x[i]    = (g == 1) ? req1_x    : req0_x;
                m_y[i]    = (g == 1) ? req1_y    : req0_y;
                m_c[i]    = (g == 1) ? req1_ctrl : req0_ctrl;
                m_res[i]  = hack_alu(m_x[i], m_y[i], m_c[i]);
                if (i == 0) q0.push_back(g); else q1.push_back(g);
            end else if (m_busy[i] && m_age[i] >= 2 && rsp_ready) begin
                m_busy[i] = 1'b0;
                m_last[i] = m_id[i];
            end
        end
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (m_busy[i]) m_age[i]++;
            check(tg("rsp_valid", i), {31'd0, rsp_valid[i]}, {31'd0, (m_busy[i] && m_age[i] >= 2)});
            if (m_busy[i] && m_age[i] == 1) begin
                check(tg("alu_x", i), {16'd0, a_x[i]}, {16'd0, m_x[i]});
                check(tg("alu_y", i), {16'd0, a_y[i]}, {16'd0, m_y[i]});
                check(tg("alu_ctrl", i),
                      {26'd0, a_zx[i], a_nx[i], a_zy[i], a_ny[i], a_f[i], a_no[i]}, {26'd0, m_c[i]});
            end
            if (m_busy[i] && m_age[i] >= 2) begin
                check(tg("rsp_id", i), {31'd0, rsp_id[i]}, {31'd0, m_id[i]});
                check(tg("rsp_res", i), {14'd0, rsp_zr[i], rsp_ng[i], rsp_out[i]}, {14'd0, m_res[i]});
            end
        end
    endtask

    // Asserts reset at the current time (asynchronously), checks every output
    // reads 0 with both requests valid, releases on a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check(tg("rst_ctl", i),
                  {20'd0, req0_ready[i], req1_ready[i], rsp_valid[i], rsp_id[i], rsp_zr[i], rsp_ng[i],
                   a_zx[i], a_nx[i], a_zy[i], a_ny[i], a_f[i], a_no[i]}, 32'd0);
            check(tg("rst_rsp_out", i), {16'd0, rsp_out[i]}, 32'd0);
            check(tg("rst_alu_xy", i), {a_x[i], a_y[i]}, 32'd0);
        end
        repeat (2) @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 1'b0;
            m_age[i]  = 0;
            m_last[i] = 1'b1;
        end
    endtask

    initial begin : stim
        logic [15:0] held;

        do_reset();

        // port 0: 5 + 3
        rsp_ready = 1'b1;
        req0_x = 16'd5; req0_y = 16'd3; req0_ctrl = 6'b000010; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        check("t1_out", {16'd0, rsp_out[0]}, 32'h0008);
        check("t1_id_zr_ng", {29'd0, rsp_id[0], rsp_zr[0], rsp_ng[0]}, 32'd0);
        tick();

        // port 1: 3 - 5, then constant 0
        req1_x = 16'd3; req1_y = 16'd5; req1_ctrl = 6'b010011; req1_valid = 1'b1;
        tick();
        req1_valid = 1'b0;
        tick();
        check("t2_out", {16'd0, rsp_out[0]}, 32'hFFFE);
        check("t2_id_zr_ng", {29'd0, rsp_id[0], rsp_zr[0], rsp_ng[0]}, 32'b101);
        tick();
        req1_ctrl = 6'b101010; req1_valid = 1'b1;
        tick();
        req1_valid = 1'b0;
        tick();
        check("t3_out_zr", {15'd0, rsp_zr[0], rsp_out[0]}, 32'h1_0000);
        tick();

        // both ports valid continuously after reset
        do_reset();
        q0.delete(); q1.delete();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (12) begin
            req0_x = 16'($urandom); req0_y = 16'($urandom); req0_ctrl = 6'($urandom);
            req1_x = 16'($urandom); req1_y = 16'($urandom); req1_ctrl = 6'($urandom);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("rr_count", q0.size(), 32'd4);
        check("fp_count", q1.size(), 32'd4);
        for (int k = 0; k < 4 && k < q0.size() && k < q1.size(); k++) begin
            check($sformatf("rr_order%0d", k), q0[k], k % 2);
            check($sformatf("fp_order%0d", k), q1[k], 0);
        end
        repeat (3) tick();

        // response backpressure with port 1 waiting
        req0_x = 16'h7FFF; req0_y = 16'h0001; req0_ctrl = 6'b000010; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0; req1_valid = 1'b1; rsp_ready = 1'b0;
        req1_x = 16'h00F0; req1_y = 16'h0F0F; req1_ctrl = 6'b000000;
        tick();
        held = rsp_out[0];
        repeat (5) tick();
        check("bp_hold_out", {16'd0, rsp_out[0]}, {16'd0, held});
        check("bp_hold_valid", {31'd0, rsp_valid[0]}, 32'd1);
        rsp_ready = 1'b1;
        tick();
        tick();
        req1_valid = 1'b0;
        repeat (3) tick();

        // async reset in the middle of EXEC
        req0_x = 16'h1234; req0_y = 16'h00FF; req0_ctrl = 6'b000010; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        #2;
        do_reset();
        req1_x = 16'h0010; req1_y = 16'h0003; req1_ctrl = 6'b000111; req1_valid = 1'b1;
        tick();
        req1_valid = 1'b0;
        repeat (3) tick();

        // port 0 op leaves last = 0, then a tie goes to port 1 and port 0 drops
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        repeat (2) tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) tick();

        // randomized traffic
        repeat (400) begin
            req0_valid = ($urandom_range(0, 1) == 1);
            req1_valid = ($urandom_range(0, 1) == 1);
            rsp_ready  = ($urandom_range(0, 9) < 7);
            req0_x = 16'($urandom); req0_y = 16'($urandom); req0_ctrl = 6'($urandom);
            req1_x = 16'($urandom); req1_y = 16'($urandom); req1_ctrl = 6'($urandom);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (4) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
